// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: zero-fills the regfile after reset, then shares its single
// write port between two valid/ready requesters with round-robin arbitration.
// Per-requester saturating stall counters are exported for performance debug.

// Per-requester saturating stall counter: counts edges where valid is held
// without a grant.
module regfile_wr_arbiter_stall_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   input  logic             i_ready,
   output logic [CNT_W-1:0] o_cnt
);

   // count stalled edges, stick at all-ones instead of wrapping
   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_cnt <= '0;
      else if (i_valid && !i_ready && !(&o_cnt))
         o_cnt <= o_cnt + 1'b1;
   end

endmodule

module regfile_wr_arbiter #(
   parameter int BW_DATA = 16,
   parameter int BW_ADDR = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_req0_valid,
   input  logic [BW_ADDR-1:0] i_req0_addr,
   input  logic [BW_DATA-1:0] i_req0_data,
   output logic               o_req0_ready,
   input  logic               i_req1_valid,
   input  logic [BW_ADDR-1:0] i_req1_addr,
   input  logic [BW_DATA-1:0] i_req1_data,
   output logic               o_req1_ready,
   output logic               o_rf_wr_en,
   output logic [BW_ADDR-1:0] o_rf_wr_addr,
   output logic [BW_DATA-1:0] o_rf_wr_data,
   output logic               o_init_done,
   output logic [7:0]         o_stall_cnt0,
   output logic [7:0]         o_stall_cnt1
);

   localparam int NUM_REQ = 2;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [BW_ADDR-1:0] addr;
      logic [BW_DATA-1:0] data;
   } wr_req_t;

   state_t                     state_q, state_d;
   // one extra bit marks "last address already issued"
   logic [BW_ADDR:0]           init_addr_q, init_addr_d;
   logic                       rr_ptr_q, rr_ptr_d;
   logic                       wr_en_q, wr_en_d;
   logic [BW_ADDR-1:0]         wr_addr_q, wr_addr_d;
   logic [BW_DATA-1:0]         wr_data_q, wr_data_d;
   logic                       init_done_q, init_done_d;

   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   wr_req_t [NUM_REQ-1:0]      req;
   logic [NUM_REQ-1:0][7:0]    stall_cnt;

   assign req_valid   = {i_req1_valid, i_req0_valid};
   assign req[0]      = '{addr: i_req0_addr, data: i_req0_data};
   assign req[1]      = '{addr: i_req1_addr, data: i_req1_data};

   assign o_req0_ready = req_ready[0];
   assign o_req1_ready = req_ready[1];
   assign o_rf_wr_en   = wr_en_q;
   assign o_rf_wr_addr = wr_addr_q;
   assign o_rf_wr_data = wr_data_q;
   assign o_init_done  = init_done_q;
   assign o_stall_cnt0 = stall_cnt[0];
   assign o_stall_cnt1 = stall_cnt[1];

   // grant: a lone valid wins; on contention the pointer picks; nothing in INIT
   always_comb begin
      req_ready = '0;
      if (state_q == ST_RUN) begin
         req_ready[0] = req_valid[0] && (!req_valid[1] || !rr_ptr_q);
         req_ready[1] = req_valid[1] && (!req_valid[0] ||  rr_ptr_q);
      end
   end

   // next state: zero-fill sweep in INIT, forward the granted request in RUN
   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      rr_ptr_d    = rr_ptr_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      init_done_d = init_done_q;
      case (state_q)
         ST_INIT: begin
            if (init_addr_q[BW_ADDR]) begin
               // every entry written; this edge only closes out the sweep
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end else begin
               wr_en_d     = 1'b1;
               wr_addr_d   = init_addr_q[BW_ADDR-1:0];
               wr_data_d   = '0;
               init_addr_d = init_addr_q + 1'b1;
            end
         end
         ST_RUN: begin
            init_done_d = 1'b1;
            // pointer always moves to the requester that was not granted
            if (req_ready[0]) begin
               wr_en_d   = 1'b1;
               wr_addr_d = req[0].addr;
               wr_data_d = req[0].data;
               rr_ptr_d  = 1'b1;
            end else if (req_ready[1]) begin
               wr_en_d   = 1'b1;
               wr_addr_d = req[1].addr;
               wr_data_d = req[1].data;
               rr_ptr_d  = 1'b0;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // state and registered write port; reset drops any pending write
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_INIT;
         init_addr_q <= '0;
         rr_ptr_q    <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         rr_ptr_q    <= rr_ptr_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         init_done_q <= init_done_d;
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stall
      regfile_wr_arbiter_stall_cnt #(.CNT_W(8)) u_cnt (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_valid (req_valid[g]),
         .i_ready (req_ready[g]),
         .o_cnt   (stall_cnt[g])
      );
   end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port controller placed in front of `regfile`. After reset it sequences a zero-fill of every entry. It then shares the single regfile write port between two requesters using valid/ready handshakes and round-robin arbitration. Per-requester stall counters are exposed for performance debug. Read ports of `regfile` are not touched by this block.

## Interface
- `BW_DATA`, default 16: data width, matches `regfile`.
- `BW_ADDR`, default 4: address width, matches `regfile`. Depth is 2**BW_ADDR.

Ports:
- `i_clk`  input  1  clock; all state updates on the rising edge.
- `i_rst`  input  1  reset. One clock; reset is synchronous and active-high.
- `i_req0_valid`  input  1  requester 0 write request.
- `i_req0_addr`  input  BW_ADDR  requester 0 target address.
- `i_req0_data`  input  BW_DATA  requester 0 write data.
- `o_req0_ready`  output  1  requester 0 request accepted this cycle when valid is also high.
- `i_req1_valid`, `i_req1_addr`, `i_req1_data`, `o_req1_ready`: same as requester 0, for requester 1.
- `o_rf_wr_en`  output  1  to `regfile` `i_rf_wr_en`, registered.
- `o_rf_wr_addr`  output  BW_ADDR  to `regfile` `i_rf_wr_addr`, registered.
- `o_rf_wr_data`  output  BW_DATA  to `regfile` `i_rf_wr_data`, registered.
- `o_init_done`  output  1  high once the zero-fill is complete.
- `o_stall_cnt0`  output  8  requester 0 stall cycles, saturating.
- `o_stall_cnt1`  output  8  requester 1 stall cycles, saturating.

## Operation
- FSM states:
  - INIT: entered on reset, zero-fills the regfile.
  - RUN: arbitrates the two requesters.
  - RUN is terminal until the next `i_rst`.
- Reset values:
  - state INIT, init address 0, round-robin pointer 0.
  - `o_rf_wr_en`, `o_rf_wr_addr`, `o_rf_wr_data` all 0.
  - `o_init_done` 0; both stall counters 0.
- INIT:
  - Each edge registers wr_en=1, addr=init address, data=0, then increments the init address.
  - After the edge that issues address 2**BW_ADDR-1, the next edge registers wr_en=0 and `o_init_done`=1, and the FSM moves to RUN.
  - Both readies are 0 throughout INIT.
- RUN, arbitration (ready signals are combinational from state, pointer and valids):
  - Exactly one valid: that requester gets ready=1.
  - Both valid: the requester equal to the pointer gets ready=1; the other gets ready=0.
  - Neither valid: both readies are 0.
- Pointer update: after a grant, the pointer moves to the non-granted requester. With no grant it holds.
- Handshake:
  - Acceptance occurs on valid&&ready at an edge.
  - That edge registers wr_en=1 with the accepted addr/data. With no acceptance, the edge registers wr_en=0.
  - Requesters hold valid, addr and data stable until accepted. Ready never depends on addr or data.
- Stall counters:
  - Increment on every edge where `i_reqN_valid`=1 and `o_reqN_ready`=0, including during INIT.
  - Saturate at 255; cleared only by `i_rst`.
- Same address from both requesters: no special handling. Writes reach the regfile in grant order, so the later grant wins.
- Reset mid-INIT or mid-RUN: the next edge applies all reset values. Zero-fill restarts at address 0. Any write already registered at that edge is dropped (wr_en forced 0).

## Timing
- Edge E1 is the first rising edge with `i_rst` sampled low.
- Edges E1..E(2**BW_ADDR) present addresses 0..2**BW_ADDR-1 with wr_en=1.
- Edge E(2**BW_ADDR+1) clears wr_en and sets `o_init_done`.
- Earliest acceptance is at edge E(2**BW_ADDR+2).
- Write latency:
  - Accepted at edge N, the write appears on `o_rf_wr_*` after edge N, and the regfile entry updates at edge N+1.
  - A combinational regfile read of that address shows new data after edge N+1.
- Throughput: one accepted write per cycle, sustained.
- With both requesters valid continuously, grants alternate every cycle.
- Ready-to-valid path: combinational. Valid-to-ready path: combinational. No combinational path from `i_req*` to `o_rf_wr_*`.

## Test plan
- Init sweep (BW_ADDR=4, regfile preloaded with 0xFFFF):
  - Release reset → wr_en high for exactly 16 cycles with addr 0..15, data 0x0000.
  - `o_init_done` rises on the 17th edge; all 16 entries read 0x0000 afterwards.
- Single requester burst:
  - Requester 0 holds valid with addr=i, data=2**i, for i=0..15, after init.
  - Required: 16 consecutive accepts; all entries read back 2**i; `o_stall_cnt0`=0.
- Contention:
  - Both valid continuously from the first RUN cycle; requester 0 uses addr 3, data 0xAAAA; requester 1 uses addr 3, data 0x5555.
  - Required: grant order 0,1,0,1 and wr_data alternating 0xAAAA/0x5555.
  - Final entry 3 equals the last granted data; each stall counter increments on alternate cycles.
- Stall during INIT and saturation:
  - Requester 1 valid from E1; grant withheld.
  - Required: `o_stall_cnt1`=17 at the first RUN edge.
  - Separately, 300 forced stall cycles → counter saturates at 255, no wrap.
- Reset mid-INIT:
  - Assert `i_rst` for one cycle after address 7 is presented.
  - Required: outputs return to 0; sweep restarts at address 0 and runs a full 16 writes.
- Reset mid-RUN:
  - Assert `i_rst` on the edge where requester 0 write (addr 5, 0x1234) is accepted.
  - Required: wr_en=0 on the next cycle; the entry is zeroed by the new sweep; pointer restarts at 0.
